// File: rtl/lenet_layer_sched_if.sv
`default_nettype none
// ============================================================================
//  Module   : lenet_layer_sched_if
//  Purpose  : Control/status bundle between a host and the LeNet layer
//             scheduler. Host side drives start/abort/range and the engines'
//             finish levels; scheduler side drives enables and status.
//  Revision : 1.0  initial release
// ============================================================================
interface lenet_layer_sched_if #(
    parameter int N_LAYERS = 6
) ();
    logic                start;
    logic                abort;
    logic [2:0]          first_layer;
    logic [2:0]          last_layer;
    logic [N_LAYERS-1:0] layer_finish;
    logic [N_LAYERS-1:0] layer_en;
    logic [2:0]          cur_layer;
    logic                busy;
    logic                done;
    logic                err_timeout;

    modport master (
        output start, abort, first_layer, last_layer, layer_finish,
        input  layer_en, cur_layer, busy, done, err_timeout
    );

    modport slave (
        input  start, abort, first_layer, last_layer, layer_finish,
        output layer_en, cur_layer, busy, done, err_timeout
    );
endinterface
`default_nettype wire

// File: rtl/lenet_layer_sched.sv
`default_nettype none
// ============================================================================
//  Module   : lenet_layer_sched
//  Purpose  : Runs the LeNet layer engines in order between a latched first
//             and last layer. Each engine gets a one-hot enable level, its
//             finish level is masked for a guard window after the enable
//             rises (engines present stale finish until they see the edge),
//             and enables stay low for a fixed gap between layers. A per-layer
//             timeout and a synchronous abort return the block to idle.
//  Revision : 1.0  initial release
// ============================================================================
module lenet_layer_sched #(
    parameter int N_LAYERS = 6,
    parameter int GUARD    = 4,
    parameter int GAP      = 2,
    parameter int TO_W     = 20
) (
    input  wire logic           clk,
    input  wire logic           rst,
    lenet_layer_sched_if.slave  bus
);

    localparam int GUARD_W = (GUARD > 1) ? $clog2(GUARD) : 1;
    localparam int GAP_W   = (GAP > 1)   ? $clog2(GAP)   : 1;

    localparam logic [3:0]         C_NL        = 4'(N_LAYERS);
    localparam logic [2:0]         C_LAST_IDX  = 3'(N_LAYERS - 1);
    localparam logic [GUARD_W-1:0] C_GUARD_END = GUARD_W'(GUARD - 1);
    localparam logic [GAP_W-1:0]   C_GAP_END   = GAP_W'(GAP - 1);
    localparam logic [TO_W-1:0]    C_TO_MAX    = '1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ARM  = 3'd1,
        S_RUN  = 3'd2,
        S_GAP  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t              r_state;
    logic [N_LAYERS-1:0] r_en;
    logic [2:0]          r_cur;
    logic [2:0]          r_last;
    logic                r_busy;
    logic                r_done;
    logic                r_err;
    logic [GUARD_W-1:0]  r_guard_cnt;
    logic [GAP_W-1:0]    r_gap_cnt;
    logic [TO_W-1:0]     r_to_cnt;

    logic [2:0]          w_first;
    logic [2:0]          w_last;
    logic                w_cur_finish;
    logic                w_to_hit;

    // One-hot enable pattern for a layer index (index is always in range).
    function automatic logic [N_LAYERS-1:0] f_onehot(input logic [2:0] idx);
        logic [N_LAYERS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Clamp the requested range: bad first -> 0, bad last -> final layer.
    always_comb begin
        w_first = bus.first_layer;
        w_last  = bus.last_layer;
        if ({1'b0, bus.first_layer} >= C_NL) begin
            w_first = 3'd0;
        end
        if (({1'b0, bus.last_layer} >= C_NL) || (bus.last_layer < w_first)) begin
            w_last = C_LAST_IDX;
        end
    end

    // Finish of the active layer only; other layers' finish levels are don't-care.
    always_comb begin
        w_cur_finish = bus.layer_finish[r_cur];
        w_to_hit     = (r_to_cnt == C_TO_MAX);
    end

    // Scheduler FSM with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_en        <= '0;
            r_cur       <= 3'd0;
            r_last      <= 3'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_guard_cnt <= '0;
            r_gap_cnt   <= '0;
            r_to_cnt    <= '0;
        end else begin
            r_done <= 1'b0;
            if (bus.abort) begin
                // Abort beats start, finish and timeout; error flag is left alone.
                r_state     <= S_IDLE;
                r_en        <= '0;
                r_busy      <= 1'b0;
                r_guard_cnt <= '0;
                r_gap_cnt   <= '0;
                r_to_cnt    <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (bus.start) begin
                            r_last      <= w_last;
                            r_err       <= 1'b0;
                            r_cur       <= w_first;
                            r_en        <= f_onehot(w_first);
                            r_busy      <= 1'b1;
                            r_guard_cnt <= '0;
                            r_to_cnt    <= '0;
                            r_state     <= S_ARM;
                        end
                    end

                    S_ARM: begin
                        // Finish is stale here; only the timeout can end the layer.
                        if (w_to_hit) begin
                            r_en    <= '0;
                            r_err   <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_to_cnt <= r_to_cnt + 1'b1;
                            if (r_guard_cnt == C_GUARD_END) begin
                                r_guard_cnt <= '0;
                                r_state     <= S_RUN;
                            end else begin
                                r_guard_cnt <= r_guard_cnt + 1'b1;
                            end
                        end
                    end

                    S_RUN: begin
                        // Finish wins over a timeout landing in the same cycle.
                        if (w_cur_finish) begin
                            r_en <= '0;
                            if (r_cur == r_last) begin
                                r_done  <= 1'b1;
                                r_busy  <= 1'b0;
                                r_state <= S_DONE;
                            end else begin
                                r_gap_cnt <= '0;
                                r_state   <= S_GAP;
                            end
                        end else if (w_to_hit) begin
                            r_en    <= '0;
                            r_err   <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_to_cnt <= r_to_cnt + 1'b1;
                        end
                    end

                    S_GAP: begin
                        // Enables low for exactly GAP cycles, then arm the next layer.
                        if (r_gap_cnt == C_GAP_END) begin
                            r_cur       <= r_cur + 3'd1;
                            r_en        <= f_onehot(r_cur + 3'd1);
                            r_guard_cnt <= '0;
                            r_to_cnt    <= '0;
                            r_state     <= S_ARM;
                        end else begin
                            r_gap_cnt <= r_gap_cnt + 1'b1;
                        end
                    end

                    S_DONE: begin
                        r_state <= S_IDLE;
                    end

                    default: begin
                        r_state <= S_IDLE;
                        r_en    <= '0;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.layer_en    = r_en;
    assign bus.cur_layer   = r_cur;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.err_timeout = r_err;

endmodule
`default_nettype wire

// File: tb/tb_lenet_layer_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lenet_layer_sched
//  Purpose  : Self-checking bench for lenet_layer_sched. Layer engines are
//             emulated by raising finish a chosen number of cycles after each
//             enable rise; expected enable windows, done pulse and timeout are
//             computed from the scheduling rules with plain arithmetic.
//  Revision : 1.0  initial release
// ============================================================================
module tb_lenet_layer_sched;

    localparam int NL     = 6;
    localparam int GUARD  = 4;
    localparam int GAP    = 2;
    localparam int TO_W   = 6;
    localparam int TO_MAX = (1 << TO_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    lenet_layer_sched_if #(.N_LAYERS(NL)) bus ();

    lenet_layer_sched #(
        .N_LAYERS (NL),
        .GUARD    (GUARD),
        .GAP      (GAP),
        .TO_W     (TO_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Cycle index: at a falling edge, cyc names the cycle since the last rising edge.
    always @(posedge clk) cyc <= cyc + 1;

    int          checks = 0;
    int          errors = 0;
    int          delay [NL];
    logic [NL-1:0] resp_fin = '0;
    logic [NL-1:0] man_fin  = '0;
    logic [NL-1:0] manual   = '0;

    assign bus.layer_finish = (resp_fin & ~manual) | (man_fin & manual);

    // Monitor log
    int          ev_layer [$];
    int          ev_rise  [$];
    int          ev_fall  [$];
    int          done_cyc [$];
    int          busy_total = 0;
    int          onehot_bad = 0;
    int          cur_rise [NL];
    logic [NL-1:0] prev_en = '0;

    // Observe enables/done on the falling edge and emulate the layer engines.
    always @(negedge clk) begin
        for (int i = 0; i < NL; i++) begin
            int rs;
            rs = cur_rise[i];
            if (bus.layer_en[i] && !prev_en[i]) begin
                rs = cyc;
                ev_layer.push_back(i);
                ev_rise.push_back(cyc);
            end
            cur_rise[i] <= rs;
            resp_fin[i] <= bus.layer_en[i] && ((cyc - rs) >= delay[i]);
        end
        if ((prev_en & ~bus.layer_en) != '0) ev_fall.push_back(cyc);
        if (bus.done) done_cyc.push_back(cyc);
        if (bus.busy) busy_total <= busy_total + 1;
        if ($countones(bus.layer_en) > 1) onehot_bad <= onehot_bad + 1;
        prev_en <= bus.layer_en;
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic set_delays(input int d);
        for (int i = 0; i < NL; i++) delay[i] = d;
    endtask

    int base_ev;
    int base_fall;
    int base_done;

    // Run one pass and compare against the arithmetic schedule model.
    task automatic run_pass(input int fi, input int li);
        int a, b, s, r, f, end_c, exp_done, explen, busy0;
        int exp_l [8];
        int exp_r [8];
        int exp_f [8];
        bit to;
        base_ev   = ev_layer.size();
        base_fall = ev_fall.size();
        base_done = done_cyc.size();
        @(negedge clk);
        busy0 = busy_total;
        s = cyc;
        bus.start       = 1'b1;
        bus.first_layer = 3'(fi);
        bus.last_layer  = 3'(li);
        @(negedge clk);
        bus.start = 1'b0;
        chk("err_clear_on_start", int'(bus.err_timeout), 0);
        chk("busy_after_start", int'(bus.busy), 1);

        a = (fi >= NL) ? 0 : fi;
        b = (li < a || li >= NL) ? NL - 1 : li;
        explen   = 0;
        r        = s + 1;
        to       = 1'b0;
        exp_done = -1;
        for (int k = a; k <= b; k++) begin
            exp_l[explen] = k;
            exp_r[explen] = r;
            f = r + ((delay[k] > GUARD) ? delay[k] : GUARD);
            if (f > r + TO_MAX) begin
                exp_f[explen] = r + TO_MAX + 1;
                explen++;
                to = 1'b1;
                break;
            end
            exp_f[explen] = f + 1;
            explen++;
            if (k == b) exp_done = f + 1;
            else        r = f + 1 + GAP;
        end
        end_c = exp_f[explen-1];
        while (cyc < end_c + 3) @(negedge clk);

        chk("n_layers_run", ev_layer.size() - base_ev, explen);
        for (int i = 0; i < explen; i++) begin
            if (base_ev + i < ev_layer.size()) begin
                chk("layer_order", ev_layer[base_ev + i], exp_l[i]);
                chk("en_rise_cycle", ev_rise[base_ev + i], exp_r[i]);
            end
            if (base_fall + i < ev_fall.size())
                chk("en_fall_cycle", ev_fall[base_fall + i], exp_f[i]);
        end
        chk("n_done", done_cyc.size() - base_done, (exp_done < 0) ? 0 : 1);
        if (exp_done >= 0 && done_cyc.size() > base_done)
            chk("done_cycle", done_cyc[base_done], exp_done);
        chk("err_timeout", int'(bus.err_timeout), int'(to));
        chk("busy_cycles", busy_total - busy0, end_c - s - 1);
        chk("busy_end", int'(bus.busy), 0);
        chk("en_end", int'(bus.layer_en), 0);
        chk("cur_layer_end", int'(bus.cur_layer), exp_l[explen-1]);
    endtask

    task automatic wait_rise(input int li, input int budget, output int rc);
        int n;
        n  = 0;
        rc = -1;
        while (n < budget && !bus.layer_en[li]) begin
            @(negedge clk);
            n++;
        end
        if (bus.layer_en[li]) rc = cyc;
        chk("wait_en_rise", int'(bus.layer_en[li]), 1);
    endtask

    typedef struct {
        int fi;
        int li;
        int ef;
        int el;
    } rng_t;

    rng_t tbl [7];

    initial begin
        int s, r, nd;

        tbl[0] = '{0, 5, 0, 5};
        tbl[1] = '{4, 5, 4, 5};
        tbl[2] = '{5, 2, 5, 5};
        tbl[3] = '{6, 3, 0, 3};
        tbl[4] = '{7, 7, 0, 5};
        tbl[5] = '{2, 2, 2, 2};
        tbl[6] = '{3, 6, 3, 5};

        bus.start       = 1'b0;
        bus.abort       = 1'b0;
        bus.first_layer = 3'd0;
        bus.last_layer  = 3'd0;
        set_delays(10);
        for (int i = 0; i < NL; i++) cur_rise[i] = 0;

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_en", int'(bus.layer_en), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_cur", int'(bus.cur_layer), 0);
        chk("rst_err", int'(bus.err_timeout), 0);

        // Full pass, each layer finishing 50 cycles after its enable
        set_delays(50);
        run_pass(0, 5);

        // Range clamping table
        set_delays(3);
        foreach (tbl[i]) begin
            run_pass(tbl[i].fi, tbl[i].li);
            if (ev_layer.size() > base_ev) begin
                chk("tbl_first", ev_layer[base_ev], tbl[i].ef);
                chk("tbl_last", ev_layer[ev_layer.size() - 1], tbl[i].el);
            end
            chk("tbl_count", ev_layer.size() - base_ev, tbl[i].el - tbl[i].ef + 1);
        end

        // Stale finish on layer 4: high at enable, dropped, re-raised 30 cycles later
        manual[4]  = 1'b1;
        man_fin[4] = 1'b1;
        base_ev   = ev_layer.size();
        base_fall = ev_fall.size();
        base_done = done_cyc.size();
        @(negedge clk);
        s = cyc;
        bus.start = 1'b1; bus.first_layer = 3'd4; bus.last_layer = 3'd4;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        man_fin[4] = 1'b0;
        while (cyc < s + 31) @(negedge clk);
        man_fin[4] = 1'b1;
        while (cyc < s + 35) @(negedge clk);
        chk("stale_n", ev_layer.size() - base_ev, 1);
        if (ev_rise.size() > base_ev) chk("stale_rise", ev_rise[base_ev], s + 1);
        if (ev_fall.size() > base_fall) chk("stale_fall", ev_fall[base_fall], s + 32);
        if (done_cyc.size() > base_done) chk("stale_done", done_cyc[base_done], s + 32);
        else chk("stale_done_seen", 0, 1);
        man_fin[4] = 1'b0;
        manual[4]  = 1'b0;
        @(negedge clk);

        // Timeout on layer 2, abort in idle keeps the error, next start clears it
        set_delays(10);
        delay[2] = 1000;
        run_pass(2, 3);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        @(negedge clk);
        chk("err_kept_on_abort", int'(bus.err_timeout), 1);
        set_delays(10);
        run_pass(0, 1);

        // Finish exactly at the timeout cycle wins; one cycle later times out
        delay[1] = TO_MAX;
        run_pass(1, 1);
        delay[1] = TO_MAX + 1;
        run_pass(1, 1);
        set_delays(10);

        // Randomized passes
        for (int n = 0; n < 10; n++) begin
            for (int i = 0; i < NL; i++) delay[i] = $urandom_range(0, 70);
            run_pass($urandom_range(0, 7), $urandom_range(0, 7));
        end
        set_delays(10);

        // Abort in RUN of layer 3 together with start and finish[3]
        manual[3]  = 1'b1;
        man_fin[3] = 1'b0;
        nd = done_cyc.size();
        @(negedge clk);
        bus.start = 1'b1; bus.first_layer = 3'd3; bus.last_layer = 3'd5;
        @(negedge clk);
        bus.start = 1'b0;
        wait_rise(3, 20, r);
        repeat (10) @(negedge clk);
        bus.abort = 1'b1; bus.start = 1'b1; bus.first_layer = 3'd0; man_fin[3] = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0; bus.start = 1'b0; man_fin[3] = 1'b0;
        chk("abort_en", int'(bus.layer_en), 0);
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_done", int'(bus.done), 0);
        repeat (5) @(negedge clk);
        chk("abort_still_idle", int'(bus.busy), 0);
        chk("abort_no_en", int'(bus.layer_en), 0);
        chk("abort_no_done", done_cyc.size() - nd, 0);
        manual[3] = 1'b0;

        // Start while busy is ignored; async reset mid-GAP clears outputs at once
        @(negedge clk);
        bus.start = 1'b1; bus.first_layer = 3'd2; bus.last_layer = 3'd5;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.start = 1'b1; bus.first_layer = 3'd4; bus.last_layer = 3'd4;
        @(negedge clk);
        bus.start = 1'b0;
        chk("busy_start_cur", int'(bus.cur_layer), 2);
        chk("busy_start_en", int'(bus.layer_en), 4);
        s = 0;
        while (s < 40 && bus.layer_en[2]) begin
            @(negedge clk);
            s++;
        end
        chk("gap_reached", int'(bus.layer_en), 0);
        chk("gap_busy", int'(bus.busy), 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", int'(bus.busy), 0);
        chk("arst_cur", int'(bus.cur_layer), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("post_rst_en", int'(bus.layer_en), 0);
        chk("post_rst_busy", int'(bus.busy), 0);

        // Async reset mid-RUN drops the enable before the next clock edge
        delay[0] = 1000;
        @(negedge clk);
        bus.start = 1'b1; bus.first_layer = 3'd0; bus.last_layer = 3'd5;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (20) @(negedge clk);
        chk("run_en_before_rst", int'(bus.layer_en), 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_en", int'(bus.layer_en), 0);
        chk("arst_busy_run", int'(bus.busy), 0);
        @(negedge clk);
        rst = 1'b0;
        set_delays(10);
        repeat (3) @(negedge clk);

        chk("onehot_enables", onehot_bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
